// File: rtl/countdown_timer_pkg.sv
// Shared state encoding for the loadable countdown timer.
// Optional auto-reload feature is selected by COUNTDOWN_AUTO_RELOAD_EN.
package countdown_timer_pkg;

  localparam int W_STATE = 2;

  typedef enum logic [W_STATE-1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with a one-cycle terminal-count pulse.
// Define COUNTDOWN_AUTO_RELOAD_EN for periodic reload from the last preset.
module countdown_timer #(
  parameter int W = 4
) (
  input  logic         C,
  input  logic         CLR,
  input  logic         LD,
  input  logic         EN,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q,
  output logic         BUSY,
  output logic         TC
);

  import countdown_timer_pkg::*;

  localparam logic [W-1:0] ONE = W'(1);

  state_t       state;
  state_t       state_n;
  logic [W-1:0] q_n;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [W-1:0] p;

  // Remember the last accepted preset for periodic reload.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      p <= '0;
    end else if (LD) begin
      p <= D;
    end
  end
`endif

  // Next state and next count; a load overrides every other action.
  always_comb begin
    state_n = state;
    q_n     = Q;
    if (LD) begin
      q_n     = D;
      state_n = (D != '0) ? S_RUN : S_DONE;
    end else begin
      case (state)
        S_IDLE: begin
          state_n = S_IDLE;
        end
        S_RUN: begin
          if (EN) begin
            if (Q > ONE) begin
              q_n = Q - ONE;
            end else begin
              q_n     = '0;
              state_n = S_DONE;
            end
          end
        end
        S_DONE: begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          q_n     = p;
          state_n = (p != '0) ? S_RUN : S_IDLE;
`else
          state_n = S_IDLE;
`endif
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  // State, count and registered status decodes.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state <= S_IDLE;
      Q     <= '0;
      BUSY  <= 1'b0;
      TC    <= 1'b0;
    end else begin
      state <= state_n;
      Q     <= q_n;
      BUSY  <= (state_n == S_RUN);
      TC    <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus
// randomized traffic compared against a behavioural count model.
module tb_countdown_timer;

  localparam int W = 4;

  logic         C = 1'b0;
  logic         CLR;
  logic         LD;
  logic         EN;
  logic [W-1:0] D;
  logic [W-1:0] Q;
  logic         BUSY;
  logic         TC;

  int cmp = 0;
  int mis = 0;

  int mq;
  int mp;
  bit mbusy;
  bit mtc;

  countdown_timer #(.W(W)) dut (
    .C    (C),
    .CLR  (CLR),
    .LD   (LD),
    .EN   (EN),
    .D    (D),
    .Q    (Q),
    .BUSY (BUSY),
    .TC   (TC)
  );

  always #5 C = ~C;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_q"}, 32'(Q), 32'(mq));
    check({tag, "_busy"}, 32'(BUSY), 32'(mbusy));
    check({tag, "_tc"}, 32'(TC), 32'(mtc));
  endtask

  task automatic model_reset();
    mq    = 0;
    mp    = 0;
    mbusy = 0;
    mtc   = 0;
  endtask

  // One clock of the timer as seen from outside: remaining count,
  // whether a countdown is in progress, and the terminal pulse.
  task automatic model_edge(input bit ld, input bit en, input int d);
    if (ld) begin
      mq    = d;
      mp    = d;
      mbusy = (d != 0);
      mtc   = (d == 0);
    end else if (mtc) begin
      mtc   = 0;
      mbusy = 0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      if (mp != 0) begin
        mq    = mp;
        mbusy = 1;
      end
`endif
    end else if (mbusy && en) begin
      mq = mq - 1;
      if (mq == 0) begin
        mbusy = 0;
        mtc   = 1;
      end
    end
  endtask

  task automatic step(input bit ld, input bit en,
                      input logic [W-1:0] d, input string tag);
    @(negedge C);
    LD = ld;
    EN = en;
    D  = d;
    @(posedge C);
    model_edge(ld, en, int'(d));
    #1;
    check_all(tag);
  endtask

  initial begin
    CLR = 1'b1;
    LD  = 1'b0;
    EN  = 1'b0;
    D   = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge C);
    CLR = 1'b0;

    // Basic countdown from 3.
    step(1'b1, 1'b0, 4'd3, "basic_ld");
    repeat (3) step(1'b0, 1'b1, 4'd0, "basic_cnt");
    repeat (3) step(1'b0, 1'b1, 4'd0, "basic_after");

    // Zero preset goes straight to the terminal pulse.
    step(1'b1, 1'b1, 4'd0, "zero_ld");
    repeat (3) step(1'b0, 1'b1, 4'd0, "zero_after");

    // Enable gaps and a mid-count reload.
    step(1'b1, 1'b0, 4'd6, "gap_ld");
    step(1'b0, 1'b1, 4'd0, "gap_a");
    step(1'b0, 1'b0, 4'd0, "gap_hold");
    step(1'b0, 1'b1, 4'd0, "gap_b");
    step(1'b0, 1'b1, 4'd0, "gap_c");
    step(1'b0, 1'b1, 4'd0, "gap_d");
    step(1'b1, 1'b1, 4'd9, "reload");
    repeat (11) step(1'b0, 1'b1, 4'd0, "reload_cnt");

    // Full range.
    step(1'b1, 1'b1, 4'd15, "full_ld");
    repeat (18) step(1'b0, 1'b1, 4'd0, "full_cnt");

    // Short preset held enabled: single or periodic pulse.
    step(1'b1, 1'b1, 4'd2, "auto_ld");
    repeat (8) step(1'b0, 1'b1, 4'd0, "auto_cnt");
    step(1'b1, 1'b0, 4'd0, "auto_stop");
    repeat (2) step(1'b0, 1'b1, 4'd0, "auto_idle");

    // Asynchronous clear in the middle of a count.
    step(1'b1, 1'b1, 4'd7, "clr_ld");
    repeat (2) step(1'b0, 1'b1, 4'd0, "clr_cnt");
    check("clr_pre_q", 32'(Q), 32'd5);
    @(negedge C);
    LD = 1'b0;
    EN = 1'b1;
    #2;
    CLR = 1'b1;
    #1;
    model_reset();
    check_all("clr_async");
    @(negedge C);
    CLR = 1'b0;
    repeat (6) step(1'b0, 1'b1, 4'd0, "clr_after");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 6) == 0,
           $urandom_range(0, 3) != 0,
           W'($urandom), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule
